// File: rtl/pc_fetch_unit.sv
// Fetch stage: owns the architectural PC, issues one imem read at a time and
// hands the returned word to decode; JumpModule redirects squash in-flight reads.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_next,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, OUT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;
  logic [31:0] ipcn_q, ipcn_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      kill_q  <= 1'b0;
      instr_q <= '0;
      ipc_q   <= '0;
      ipcn_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      kill_q  <= kill_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      ipcn_q  <= ipcn_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    kill_d  = kill_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    ipcn_d  = ipcn_q;
    case (state_q)
      IDLE: begin
        if (redirect) pc_d = redirect_pc;
        if (en)       state_d = REQ;
      end
      REQ: begin
        // The old-pc read is already on the bus; a redirect here marks it for drop.
        state_d = WAIT;
        if (redirect) begin
          pc_d   = redirect_pc;
          kill_d = 1'b1;
        end
      end
      WAIT: begin
        if (imem_valid) begin
          if (redirect) begin
            pc_d    = redirect_pc;
            kill_d  = 1'b0;
            state_d = REQ;
          end else if (kill_q) begin
            kill_d  = 1'b0;
            state_d = REQ;
          end else begin
            instr_d = imem_rdata;
            ipc_d   = pc_q;
            ipcn_d  = pc_q + PC_STEP;
            state_d = OUT;
          end
        end else if (redirect) begin
          pc_d   = redirect_pc;
          kill_d = 1'b1;
        end
      end
      OUT: begin
        // Redirect beats the handshake: the held instruction is discarded.
        if (redirect) begin
          pc_d    = redirect_pc;
          state_d = en ? REQ : IDLE;
        end else if (if_ready) begin
          pc_d    = pc_q + PC_STEP;
          state_d = en ? REQ : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign imem_req   = (state_q == REQ);
  assign imem_addr  = imem_req ? pc_q : '0;
  assign if_valid   = (state_q == OUT);
  assign if_instr   = instr_q;
  assign if_pc      = ipc_q;
  assign if_pc_next = ipcn_q;
  assign busy       = (state_q == REQ) || (state_q == WAIT) || kill_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: default instance (a) plus a wrap/step-1
// instance (b), each fed by a fixed-latency imem model.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel, en, redirect, if_ready;
  logic [31:0] rpc;
  int          lat;
  int          nchk = 0, nerr = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return a ^ 32'hC0DE_5A5A;
  endfunction

  logic        a_en, a_redir, a_rdy, a_req, a_mv, a_iv, a_busy;
  logic [31:0] a_addr, a_md, a_instr, a_pc, a_pcn;
  logic        b_en, b_redir, b_rdy, b_req, b_mv, b_iv, b_busy;
  logic [31:0] b_addr, b_md, b_instr, b_pc, b_pcn;

  assign a_en = en & ~sel;       assign b_en = en & sel;
  assign a_redir = redirect & ~sel; assign b_redir = redirect & sel;
  assign a_rdy = if_ready & ~sel; assign b_rdy = if_ready & sel;

  pc_fetch_unit u_a (
    .clk(clk), .rst(rst), .en(a_en), .redirect(a_redir), .redirect_pc(rpc),
    .imem_req(a_req), .imem_addr(a_addr), .imem_valid(a_mv), .imem_rdata(a_md),
    .if_valid(a_iv), .if_ready(a_rdy), .if_instr(a_instr), .if_pc(a_pc),
    .if_pc_next(a_pcn), .busy(a_busy)
  );

  pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .PC_STEP(32'd1)) u_b (
    .clk(clk), .rst(rst), .en(b_en), .redirect(b_redir), .redirect_pc(rpc),
    .imem_req(b_req), .imem_addr(b_addr), .imem_valid(b_mv), .imem_rdata(b_md),
    .if_valid(b_iv), .if_ready(b_rdy), .if_instr(b_instr), .if_pc(b_pc),
    .if_pc_next(b_pcn), .busy(b_busy)
  );

  // imem models: one outstanding read, data valid 'lat' cycles after the request
  logic [2:0]  a_cnt, b_cnt;
  logic [31:0] a_dat, b_dat;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      a_cnt <= '0; a_dat <= '0; b_cnt <= '0; b_dat <= '0;
    end else begin
      if (a_req) begin a_cnt <= lat[2:0]; a_dat <= mem_f(a_addr); end
      else if (a_cnt != 0) a_cnt <= a_cnt - 3'd1;
      if (b_req) begin b_cnt <= lat[2:0]; b_dat <= mem_f(b_addr); end
      else if (b_cnt != 0) b_cnt <= b_cnt - 3'd1;
    end
  end
  assign a_mv = (a_cnt == 3'd1); assign a_md = a_mv ? a_dat : '0;
  assign b_mv = (b_cnt == 3'd1); assign b_md = b_mv ? b_dat : '0;

  logic        c_req, c_iv, c_busy;
  logic [31:0] c_addr, c_instr, c_pc, c_pcn;
  assign c_req   = sel ? b_req   : a_req;
  assign c_iv    = sel ? b_iv    : a_iv;
  assign c_busy  = sel ? b_busy  : a_busy;
  assign c_addr  = sel ? b_addr  : a_addr;
  assign c_instr = sel ? b_instr : a_instr;
  assign c_pc    = sel ? b_pc    : a_pc;
  assign c_pcn   = sel ? b_pcn   : a_pcn;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_req(input string tag, input logic [31:0] exp);
    bit found = 0;
    for (int n = 0; n < 20 && !found; n++) begin
      step();
      found = c_req;
    end
    chk({tag, "_seen"}, {31'd0, found}, 32'd1);
    chk(tag, c_addr, exp);
  endtask

  task automatic wait_out(input string tag);
    bit found = 0;
    for (int n = 0; n < 20 && !found; n++) begin
      step();
      found = c_iv;
    end
    chk(tag, {31'd0, found}, 32'd1);
  endtask

  task automatic idle_cycles(input string tag, input int n);
    logic seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      step();
      seen |= c_req;
    end
    chk(tag, {31'd0, seen}, 32'd0);
  endtask

  logic [31:0] hold_instr;
  logic        bp_bad, seen_iv;
  bit          found;

  initial begin
    sel = 0; en = 0; redirect = 0; rpc = '0; if_ready = 0; lat = 3;
    repeat (2) step();
    rst = 0; en = 1;
    wait_req("first_addr", 32'h0);
    step();                              // now in WAIT with 3-cycle imem
    #2 rst = 1; #1;
    chk("rst_req",   {31'd0, a_req}, 0);
    chk("rst_addr",  a_addr, 0);
    chk("rst_valid", {31'd0, a_iv}, 0);
    chk("rst_instr", a_instr, 0);
    chk("rst_pc",    a_pc, 0);
    chk("rst_pcn",   a_pcn, 0);
    chk("rst_busy",  {31'd0, a_busy}, 0);
    step(); en = 0; rst = 0;
    idle_cycles("idle_no_req", 3);

    // sequential fetch, 1-cycle imem, decode always ready
    en = 1; lat = 1; if_ready = 1;
    for (int k = 0; k < 4; k++) begin
      wait_req($sformatf("seq_addr%0d", k), 32'(4 * k));
      wait_out("seq_out");
      chk("seq_instr", c_instr, mem_f(32'(4 * k)));
      chk("seq_pc",    c_pc, 32'(4 * k));
      chk("seq_pcn",   c_pcn, 32'(4 * k + 4));
    end

    // backpressure
    wait_req("bp_addr", 32'h10);
    if_ready = 0;
    wait_out("bp_out");
    hold_instr = c_instr; bp_bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (!c_iv || c_req || c_instr !== hold_instr || c_pc !== 32'h10) bp_bad = 1;
    end
    chk("bp_hold", {31'd0, bp_bad}, 0);
    chk("bp_instr", hold_instr, mem_f(32'h10));
    if_ready = 1;
    wait_req("bp_next", 32'h14);
    wait_out("out20");

    // redirect in OUT beats if_ready
    redirect = 1; rpc = 32'h8; step(); redirect = 0;
    chk("rdo_req",   {31'd0, c_req}, 1);
    chk("rdo_addr",  c_addr, 32'h8);
    chk("rdo_valid", {31'd0, c_iv}, 0);

    // redirect one cycle after request at 8, 3-cycle imem
    lat = 3; step();
    redirect = 1; rpc = 32'h40; step(); redirect = 0;
    chk("rdw_busy", {31'd0, c_busy}, 1);
    seen_iv = 0; found = 0;
    for (int n = 0; n < 10 && !found; n++) begin
      step();
      seen_iv |= c_iv;
      found = c_req;
    end
    chk("rdw_seen", {31'd0, found}, 1);
    chk("rdw_drop", {31'd0, seen_iv}, 0);
    chk("rdw_addr", c_addr, 32'h40);
    lat = 1;
    wait_out("out40");
    chk("out40_instr", c_instr, mem_f(32'h40));

    // accept with en=0 -> IDLE; redirect while idle
    en = 0; step();
    chk("idle_valid", {31'd0, c_iv}, 0);
    redirect = 1; rpc = 32'h14; step(); redirect = 0;
    idle_cycles("rdi_no_req", 3);
    en = 1;
    wait_req("rdi_addr", 32'h14);
    wait_out("out14");
    chk("out14_pc",  c_pc, 32'h14);
    chk("out14_pcn", c_pcn, 32'h18);

    // wrap at 2^32 with PC_STEP=4
    redirect = 1; rpc = 32'hFFFF_FFFC; step(); redirect = 0;
    chk("wrap_addr", c_addr, 32'hFFFF_FFFC);
    wait_out("wrap_out");
    chk("wrap_pcn", c_pcn, 32'h0);
    wait_req("wrap_next", 32'h0);
    en = 0;
    wait_out("wrap_last");
    step();

    // instance b: RESET_PC=FFFF_FFFC, PC_STEP=1
    sel = 1; en = 1;
    wait_req("b_first", 32'hFFFF_FFFC);
    wait_out("b_out0");
    chk("b_pcn", c_pcn, 32'hFFFF_FFFD);
    redirect = 1; rpc = 32'h3; step(); redirect = 0;
    chk("b_addr3", c_addr, 32'h3);
    wait_out("b_out3");
    chk("b_pcn3", c_pcn, 32'h4);
    wait_req("b_addr4", 32'h4);
    wait_out("b_out4");
    wait_req("b_addr5", 32'h5);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
